// File: rtl/svc_soc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : svc_soc_io_bank
// Purpose  : SoC I/O register bank. LED and GPIO registers, a synchronised
//            GPIO input, TX/RX byte FIFOs toward external UART blocks,
//            a 64-bit cycle counter with a coherent high-word shadow and an
//            RX interrupt.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module svc_soc_io_bank #(
  parameter int LED_WIDTH  = 4,
  parameter int GPIO_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_wen,
  input  logic [31:0]           io_waddr,
  input  logic [31:0]           io_wdata,
  input  logic [3:0]            io_wstrb,
  input  logic                  io_ren,
  input  logic [31:0]           io_raddr,
  output logic [31:0]           io_rdata,
  output logic [LED_WIDTH-1:0]  led,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic                  utx_valid,
  output logic [7:0]            utx_data,
  input  logic                  utx_ready,
  input  logic                  urx_valid,
  input  logic [7:0]            urx_data,
  output logic                  urx_ready,
  output logic                  irq
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);

  // Word indices (byte address bits [7:2])
  localparam logic [5:0] C_ADDR_LED      = 6'd0;
  localparam logic [5:0] C_ADDR_GPIO_OUT = 6'd1;
  localparam logic [5:0] C_ADDR_GPIO_IN  = 6'd2;
  localparam logic [5:0] C_ADDR_TX_DATA  = 6'd3;
  localparam logic [5:0] C_ADDR_STATUS   = 6'd4;
  localparam logic [5:0] C_ADDR_RX_DATA  = 6'd5;
  localparam logic [5:0] C_ADDR_CYC_LO   = 6'd6;
  localparam logic [5:0] C_ADDR_CYC_HI   = 6'd7;
  localparam logic [5:0] C_ADDR_CTRL     = 6'd8;

  // Merge byte lanes of new data into a 32-bit view of a register.
  function automatic logic [31:0] f_merge(input logic [31:0] cur,
                                          input logic [31:0] data,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- state
  logic [LED_WIDTH-1:0]  r_led;
  logic [GPIO_WIDTH-1:0] r_gpio_out;
  logic [GPIO_WIDTH-1:0] r_gpio_s1;
  logic [GPIO_WIDTH-1:0] r_gpio_s2;
  logic                  r_ctrl_irq_en;
  logic                  r_rx_ovf;
  logic                  r_tx_ovf;
  logic [63:0]           r_cycle;
  logic [31:0]           r_cyc_hi_shadow;
  logic [31:0]           r_rdata;
  logic                  r_irq;

  logic [7:0]            r_tx_mem [TX_DEPTH];
  logic [TX_AW:0]        r_tx_wr;
  logic [TX_AW:0]        r_tx_rd;
  logic [7:0]            r_rx_mem [RX_DEPTH];
  logic [RX_AW:0]        r_rx_wr;
  logic [RX_AW:0]        r_rx_rd;

  // ---------------------------------------------------------------- decode
  logic [5:0] w_widx;
  logic [5:0] w_ridx;
  logic       w_wr_led, w_wr_gpio, w_wr_txd, w_wr_status, w_wr_ctrl;
  logic       w_rd_rxd, w_rd_cyc_lo;

  assign w_widx      = io_waddr[7:2];
  assign w_ridx      = io_raddr[7:2];
  assign w_wr_led    = io_wen && (w_widx == C_ADDR_LED);
  assign w_wr_gpio   = io_wen && (w_widx == C_ADDR_GPIO_OUT);
  assign w_wr_txd    = io_wen && (w_widx == C_ADDR_TX_DATA);
  assign w_wr_status = io_wen && (w_widx == C_ADDR_STATUS);
  assign w_wr_ctrl   = io_wen && (w_widx == C_ADDR_CTRL);
  assign w_rd_rxd    = io_ren && (w_ridx == C_ADDR_RX_DATA);
  assign w_rd_cyc_lo = io_ren && (w_ridx == C_ADDR_CYC_LO);

  // ---------------------------------------------------------------- LED / GPIO
  logic [31:0] w_led_ext, w_gpio_ext, w_gpio_in_ext;
  logic [31:0] w_led_next, w_gpio_next;

  // Zero-extended 32-bit views of the narrow registers for merge and readback
  always_comb begin
    w_led_ext                       = '0;
    w_led_ext[LED_WIDTH-1:0]        = r_led;
    w_gpio_ext                      = '0;
    w_gpio_ext[GPIO_WIDTH-1:0]      = r_gpio_out;
    w_gpio_in_ext                   = '0;
    w_gpio_in_ext[GPIO_WIDTH-1:0]   = r_gpio_s2;
  end

  assign w_led_next  = f_merge(w_led_ext, io_wdata, io_wstrb);
  assign w_gpio_next = f_merge(w_gpio_ext, io_wdata, io_wstrb);

  // Byte-strobed LED/GPIO output registers and the control bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led         <= '0;
      r_gpio_out    <= '0;
      r_ctrl_irq_en <= 1'b0;
    end else begin
      if (w_wr_led)  r_led      <= w_led_next[LED_WIDTH-1:0];
      if (w_wr_gpio) r_gpio_out <= w_gpio_next[GPIO_WIDTH-1:0];
      if (w_wr_ctrl && io_wstrb[0]) r_ctrl_irq_en <= io_wdata[0];
    end
  end

  // Two-flop synchroniser for the asynchronous GPIO inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio_s1 <= '0;
      r_gpio_s2 <= '0;
    end else begin
      r_gpio_s1 <= gpio_in;
      r_gpio_s2 <= r_gpio_s1;
    end
  end

  // ---------------------------------------------------------------- TX FIFO
  logic w_tx_empty, w_tx_full, w_tx_pop, w_tx_push_req, w_tx_push, w_tx_drop;

  assign w_tx_empty    = (r_tx_wr == r_tx_rd);
  assign w_tx_full     = (r_tx_wr[TX_AW] != r_tx_rd[TX_AW]) &&
                         (r_tx_wr[TX_AW-1:0] == r_tx_rd[TX_AW-1:0]);
  assign w_tx_pop      = !w_tx_empty && utx_ready;
  assign w_tx_push_req = w_wr_txd && io_wstrb[0];
  // A pop in the same cycle frees the slot, so a push while full still lands
  assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);
  assign w_tx_drop     = w_tx_push_req && w_tx_full && !w_tx_pop;

  // TX storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr[TX_AW-1:0]] <= io_wdata[7:0];
  end

  // TX read/write pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_wr <= '0;
      r_tx_rd <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + {{TX_AW{1'b0}}, 1'b1};
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + {{TX_AW{1'b0}}, 1'b1};
    end
  end

  assign utx_valid = !w_tx_empty;
  assign utx_data  = r_tx_mem[r_tx_rd[TX_AW-1:0]];

  // ---------------------------------------------------------------- RX FIFO
  logic       w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_drop;
  logic [7:0] w_rx_head;

  assign w_rx_empty = (r_rx_wr == r_rx_rd);
  assign w_rx_full  = (r_rx_wr[RX_AW] != r_rx_rd[RX_AW]) &&
                      (r_rx_wr[RX_AW-1:0] == r_rx_rd[RX_AW-1:0]);
  assign w_rx_pop   = w_rd_rxd && !w_rx_empty;
  assign w_rx_push  = urx_valid && (!w_rx_full || w_rx_pop);
  assign w_rx_drop  = urx_valid && w_rx_full && !w_rx_pop;
  assign w_rx_head  = r_rx_mem[r_rx_rd[RX_AW-1:0]];

  // RX storage
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr[RX_AW-1:0]] <= urx_data;
  end

  // RX read/write pointers with wrap bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_wr <= '0;
      r_rx_rd <= '0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + {{RX_AW{1'b0}}, 1'b1};
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + {{RX_AW{1'b0}}, 1'b1};
    end
  end

  // The UART receiver cannot be back-pressured
  assign urx_ready = 1'b1;

  // ---------------------------------------------------------------- sticky flags
  // Overflow flags: a new drop wins over a same-cycle write-one-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_ovf <= 1'b0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_rx_drop)
        r_rx_ovf <= 1'b1;
      else if (w_wr_status && io_wstrb[0] && io_wdata[3])
        r_rx_ovf <= 1'b0;
      if (w_tx_drop)
        r_tx_ovf <= 1'b1;
      else if (w_wr_status && io_wstrb[0] && io_wdata[4])
        r_tx_ovf <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- cycle counter
  // Free-running counter; a CYCLE_LO read snapshots the high word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle         <= '0;
      r_cyc_hi_shadow <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_rd_cyc_lo) r_cyc_hi_shadow <= r_cycle[63:32];
    end
  end

  // ---------------------------------------------------------------- read path
  logic [31:0] w_rdata;

  // Read mux built from pre-write state so same-cycle writes are not visible
  always_comb begin
    w_rdata = '0;
    case (w_ridx)
      C_ADDR_LED:      w_rdata = w_led_ext;
      C_ADDR_GPIO_OUT: w_rdata = w_gpio_ext;
      C_ADDR_GPIO_IN:  w_rdata = w_gpio_in_ext;
      C_ADDR_TX_DATA:  w_rdata = '0;
      C_ADDR_STATUS:   w_rdata = {27'd0, r_tx_ovf, r_rx_ovf, !w_rx_empty,
                                  w_tx_empty, w_tx_full};
      C_ADDR_RX_DATA:  w_rdata = w_rx_empty ? 32'd0 : {1'b1, 23'd0, w_rx_head};
      C_ADDR_CYC_LO:   w_rdata = r_cycle[31:0];
      C_ADDR_CYC_HI:   w_rdata = r_cyc_hi_shadow;
      C_ADDR_CTRL:     w_rdata = {31'd0, r_ctrl_irq_en};
      default:         w_rdata = '0;
    endcase
  end

  // Registered read data, held while no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else if (io_ren) r_rdata <= w_rdata;
  end

  assign io_rdata = r_rdata;

  // ---------------------------------------------------------------- interrupt
  // RX interrupt, registered one cycle behind its condition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_irq <= 1'b0;
    else        r_irq <= r_ctrl_irq_en && !w_rx_empty;
  end

  assign irq      = r_irq;
  assign led      = r_led;
  assign gpio_out = r_gpio_out;

  // Address bits outside the decode window and truncated merge results
  logic w_unused;
  assign w_unused = &{1'b0, io_waddr[31:8], io_waddr[1:0], io_raddr[31:8],
                      io_raddr[1:0], w_led_next, w_gpio_next};

endmodule
`default_nettype wire

// File: tb/tb_svc_soc_io_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_svc_soc_io_bank
// Purpose  : Scoreboard bench for svc_soc_io_bank. Read expectations and TX
//            byte expectations are queued at stimulus time and retired when
//            the DUT produces read data or emits a TX byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_svc_soc_io_bank;

  logic        clk;
  logic        rst_n;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic [3:0]  led;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_in;
  logic        utx_valid;
  logic [7:0]  utx_data;
  logic        utx_ready;
  logic        urx_valid;
  logic [7:0]  urx_data;
  logic        urx_ready;
  logic        irq;

  int total;
  int bad;

  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [63:0] tb_cyc;

  svc_soc_io_bank #(
    .LED_WIDTH (4),
    .GPIO_WIDTH(8),
    .TX_DEPTH  (16),
    .RX_DEPTH  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_wen   (io_wen),
    .io_waddr (io_waddr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .io_ren   (io_ren),
    .io_raddr (io_raddr),
    .io_rdata (io_rdata),
    .led      (led),
    .gpio_out (gpio_out),
    .gpio_in  (gpio_in),
    .utx_valid(utx_valid),
    .utx_data (utx_data),
    .utx_ready(utx_ready),
    .urx_valid(urx_valid),
    .urx_data (urx_data),
    .urx_ready(urx_ready),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference cycle count: posedges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 64'd0;
    else        tb_cyc <= tb_cyc + 64'd1;
  end

  // Retire scoreboard entries when the DUT produces read data / TX bytes
  logic        mon_rf;
  logic        mon_tf;
  logic [7:0]  mon_td;
  logic [31:0] mon_e;
  always @(posedge clk) begin
    mon_rf = io_ren && rst_n;
    mon_tf = utx_valid && utx_ready && rst_n;
    mon_td = utx_data;
    #1;
    if (mon_rf) begin
      if (exp_q.size() == 0) check("rd_sb_empty", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rdata", io_rdata, mon_e);
      end
    end
    if (mon_tf) begin
      if (tx_q.size() == 0) check("tx_unexpected", {24'd0, mon_td}, 32'd0);
      else begin
        mon_e = {24'd0, tx_q.pop_front()};
        check("tx_byte", {24'd0, mon_td}, mon_e);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    io_wen = 1'b1; io_waddr = a; io_wdata = d; io_wstrb = s;
    @(negedge clk);
    io_wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    io_ren = 1'b1; io_raddr = a;
    exp_q.push_back(e);
    @(negedge clk);
    io_ren = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    @(negedge clk);
    urx_valid = 1'b1; urx_data = b;
    @(negedge clk);
    urx_valid = 1'b0;
  endtask

  task automatic wait_tx_drain();
    for (int i = 0; i < 200 && tx_q.size() != 0; i++) @(negedge clk);
    check("tx_drain_timeout", tx_q.size(), 32'd0);
  endtask

  // Hard stop in case a task blocks unexpectedly
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; io_wen = 1'b0; io_waddr = '0; io_wdata = '0; io_wstrb = '0;
    io_ren = 1'b0; io_raddr = '0; gpio_in = 8'h5A; utx_ready = 1'b0;
    urx_valid = 1'b0; urx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_led", led, 0);
    check("rst_gpio_out", gpio_out, 0);
    check("rst_rdata", io_rdata, 0);
    check("rst_utx_valid", utx_valid, 0);
    check("rst_irq", irq, 0);
    check("rst_urx_ready", urx_ready, 1);
    rst_n = 1'b1;

    // LED / GPIO registers, strobes, aliasing, unmapped space
    wr(32'h00, 32'h0000_00A5, 4'b0001);
    check("led_wr", led, 4'h5);
    rd(32'h00, 32'h5);
    wr(32'h04, 32'hFFFF_3C12, 4'b0001);
    wr(32'h04, 32'h0000_7700, 4'b0010);
    check("gpio_strb", gpio_out, 8'h12);
    rd(32'h04, 32'h12);
    wr(32'h24, 32'hFFFF_FFFF, 4'hF);
    rd(32'h24, 32'h0);
    rd(32'hFC, 32'h0);
    rd(32'h100, 32'h5);
    @(negedge clk);
    check("rdata_hold", io_rdata, 32'h5);
    rd(32'h08, 32'h5A);
    // Same-cycle read and write of LED: read sees old value
    @(negedge clk);
    io_wen = 1'b1; io_waddr = 32'h00; io_wdata = 32'h3; io_wstrb = 4'b0001;
    io_ren = 1'b1; io_raddr = 32'h00; exp_q.push_back(32'h5);
    @(negedge clk);
    io_wen = 1'b0; io_ren = 1'b0;
    check("led_after_rw", led, 4'h3);

    // TX overflow and drain
    for (int i = 1; i <= 17; i++) begin
      wr(32'h0C, i, 4'b0001);
      if (i <= 16) tx_q.push_back(8'(i));
    end
    rd(32'h10, 32'h11);
    rd(32'h0C, 32'h0);
    utx_ready = 1'b1;
    wait_tx_drain();
    rd(32'h10, 32'h12);
    wr(32'h10, 32'h10, 4'b0001);
    rd(32'h10, 32'h02);

    // Push and pop together while full: push accepted
    utx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wr(32'h0C, 32'h20 + i, 4'b0001);
      tx_q.push_back(8'(8'h20 + i));
    end
    rd(32'h10, 32'h01);
    @(negedge clk);
    io_wen = 1'b1; io_waddr = 32'h0C; io_wdata = 32'h30; io_wstrb = 4'b0001;
    utx_ready = 1'b1; tx_q.push_back(8'h30);
    @(negedge clk);
    io_wen = 1'b0;
    wait_tx_drain();
    rd(32'h10, 32'h02);

    // RX path with interrupt
    wr(32'h20, 32'h1, 4'b0001);
    rd(32'h20, 32'h1);
    rx_byte(8'h41);
    check("irq_latency0", irq, 0);
    @(negedge clk);
    check("irq_rise", irq, 1);
    rx_byte(8'h42);
    rd(32'h14, 32'h8000_0041);
    check("irq_held", irq, 1);
    rd(32'h14, 32'h8000_0042);
    check("irq_lag", irq, 1);
    @(negedge clk);
    check("irq_fall", irq, 0);
    rd(32'h14, 32'h0);
    rd(32'h10, 32'h02);

    // RX full: simultaneous receive + pop accepted, lone receive dropped
    for (int i = 0; i < 16; i++) rx_byte(8'(8'h60 + i));
    rd(32'h10, 32'h06);
    @(negedge clk);
    urx_valid = 1'b1; urx_data = 8'h70;
    io_ren = 1'b1; io_raddr = 32'h14; exp_q.push_back(32'h8000_0060);
    @(negedge clk);
    urx_valid = 1'b0; io_ren = 1'b0;
    rd(32'h10, 32'h06);
    rx_byte(8'h71);
    rd(32'h10, 32'h0E);
    for (int i = 1; i < 16; i++) rd(32'h14, 32'h8000_0060 + i);
    rd(32'h14, 32'h8000_0070);
    rd(32'h14, 32'h0);
    wr(32'h10, 32'h08, 4'b0001);
    rd(32'h10, 32'h02);
    check("irq_after_drain", irq, 0);

    // Cycle counter low/high pair
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      io_ren = 1'b1; io_raddr = 32'h18; exp_q.push_back(tb_cyc[31:0]);
      @(negedge clk);
      io_ren = 1'b0;
      rd(32'h1C, 32'h0);
    end

    // Asynchronous reset in the middle of TX activity
    gpio_in = 8'hC3;
    utx_ready = 1'b0;
    wr(32'h0C, 32'h55, 4'b0001);
    wr(32'h0C, 32'h66, 4'b0001);
    wr(32'h00, 32'hF, 4'b0001);
    rd(32'h08, 32'hC3);
    rx_byte(8'h99);
    @(negedge clk);
    check("pre_rst_utx_valid", utx_valid, 1);
    check("pre_rst_irq", irq, 1);
    check("pre_rst_led", led, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_utx_valid", utx_valid, 0);
    check("async_rst_irq", irq, 0);
    check("async_rst_led", led, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h10, 32'h02);
    rd(32'h14, 32'h0);
    rd(32'h20, 32'h0);
    rd(32'h1C, 32'h0);
    repeat (2) @(negedge clk);
    check("post_rst_utx_valid", utx_valid, 0);
    check("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
